calc_arbiter: RTL

Two-port request arbiter and sequencer in front of the full-calculator top. It accepts operation requests (opcode plus two operands) from two independent requesters and grants them round-robin. It drives the calculator's Go/F/X/Y and holds them stable for the whole operation. It waits for completion, error or timeout, then returns the result and status to the granted requester with a one-cycle acknowledge.

---
 rtl/calc_pkg.sv | 26 ++
 rtl/calc_rr_pick.sv | 24 ++
 rtl/calc_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: opcodes, arbiter
// state encoding and the requester identifier.
package calc_pkg;

    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_SUB     = 3'b001;
    localparam logic [2:0] OP_MUL     = 3'b010;
    localparam logic [2:0] OP_DIV     = 3'b011;
    localparam logic [2:0] OP_INC     = 3'b100;
    localparam logic [2:0] OP_DEC     = 3'b101;
    localparam logic [2:0] OP_SQR     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/calc_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes
// to the port that was not granted last.
module calc_rr_pick
    import calc_pkg::*;
(
    input  logic  req_a,
    input  logic  req_b,
    input  port_t last_grant,
    output logic  grant_valid,
    output port_t grant_sel
);

    // Pick the winner from the current requests and the previous grant.
    always_comb begin
        grant_valid = req_a | req_b;
        grant_sel   = PORT_A;
        if (req_a && req_b) begin
            grant_sel = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b) begin
            grant_sel = PORT_B;
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Two-port arbiter and sequencer in front of the calculator. Grants one
// requester, issues a single Go pulse with registered opcode/operands,
// waits for done, error or timeout and returns the outcome with a
// one-cycle acknowledge to the granted port.
module calc_arbiter
    import calc_pkg::*;
#(
    parameter int W       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_a,
    input  logic         req_b,
    input  logic [2:0]   f_a,
    input  logic [2:0]   f_b,
    input  logic [W-1:0] x_a,
    input  logic [W-1:0] y_a,
    input  logic [W-1:0] x_b,
    input  logic [W-1:0] y_b,
    output logic         ack_a,
    output logic         ack_b,
    output logic [W-1:0] res_h,
    output logic [W-1:0] res_l,
    output logic         err,
    output logic         tmo,
    output logic         calc_go,
    output logic [2:0]   calc_f,
    output logic [W-1:0] calc_x,
    output logic [W-1:0] calc_y,
    input  logic         calc_done,
    input  logic         calc_err,
    input  logic [W-1:0] calc_out_h,
    input  logic [W-1:0] calc_out_l,
    output logic         busy
);

    localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t     state;
    arb_state_t     state_nxt;
    logic [CW-1:0]  cnt;
    port_t          last_grant;
    port_t          grant_q;
    port_t          grant_sel;
    logic           grant_valid;
    logic [2:0]     sel_f;
    logic [W-1:0]   sel_x;
    logic [W-1:0]   sel_y;
    logic [W-1:0]   res_h_q;
    logic [W-1:0]   res_l_q;
    logic           err_q;
    logic           tmo_q;
    logic           timeout_hit;

    calc_rr_pick u_pick (
        .req_a       (req_a),
        .req_b       (req_b),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_sel   (grant_sel)
    );

    assign timeout_hit = (cnt == CNT_LAST);

    // Route the winning requester's opcode and operands toward the latches.
    always_comb begin
        sel_f = (grant_sel == PORT_B) ? f_b : f_a;
        sel_x = (grant_sel == PORT_B) ? x_b : x_a;
        sel_y = (grant_sel == PORT_B) ? y_b : y_a;
    end

    // State register; reset mid-operation abandons whatever was in flight.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decision; done beats error beats timeout in WAIT.
    always_comb begin
        // NOTE: default assignment first, so no path leaves state_nxt
        // unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt = (sel_f == OP_ILLEGAL) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (calc_done || calc_err || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Grant bookkeeping, operand latches, wait counter and captured result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            last_grant <= PORT_B;
            grant_q    <= PORT_A;
            calc_f     <= 3'b000;
            calc_x     <= '0;
            calc_y     <= '0;
            res_h_q    <= '0;
            res_l_q    <= '0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        grant_q <= grant_sel;
                        if (sel_f == OP_ILLEGAL) begin
                            // Rejected without touching the calculator.
                            res_h_q <= '0;
                            res_l_q <= '0;
                            err_q   <= 1'b1;
                            tmo_q   <= 1'b0;
                        end else begin
                            calc_f <= sel_f;
                            calc_x <= sel_x;
                            calc_y <= sel_y;
                            cnt    <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (calc_done) begin
                        res_h_q <= calc_out_h;
                        res_l_q <= calc_out_l;
                        err_q   <= 1'b0;
                        tmo_q   <= 1'b0;
                    end else if (calc_err) begin
                        res_h_q <= '0;
                        res_l_q <= '0;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        res_h_q <= '0;
                        res_l_q <= '0;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                    end
                end
                ST_RESP: last_grant <= grant_q;
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; result fields are only driven in RESP.
    always_comb begin
        calc_go = (state == ST_ISSUE);
        busy    = (state != ST_IDLE);
        ack_a   = (state == ST_RESP) && (grant_q == PORT_A);
        ack_b   = (state == ST_RESP) && (grant_q == PORT_B);
        res_h   = (state == ST_RESP) ? res_h_q : '0;
        res_l   = (state == ST_RESP) ? res_l_q : '0;
        err     = (state == ST_RESP) && err_q;
        tmo     = (state == ST_RESP) && tmo_q;
    end

endmodule
